// File: rtl/pe_arbiter.sv
// Round-robin, burst-granular arbiter: four first-word-fall-through FIFO read
// ports share one downstream FIFO write port.

module pe_arb_lane #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  sel,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rd,
  output logic [DATA_WIDTH-1:0] dout_m
);
  assign rd     = sel & wr;
  assign dout_m = sel ? dout : '0;
endmodule

module pe_arbiter #(
  parameter int DATA_WIDTH  = 128,
  parameter int BURST_LEN   = 4,
  parameter int STALL_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rd0,
  output logic                  rd1,
  output logic                  rd2,
  output logic                  rd3,
  input  logic                  vld0,
  input  logic                  vld1,
  input  logic                  vld2,
  input  logic                  vld3,
  input  logic [DATA_WIDTH-1:0] dout0,
  input  logic [DATA_WIDTH-1:0] dout1,
  input  logic [DATA_WIDTH-1:0] dout2,
  input  logic [DATA_WIDTH-1:0] dout3,
  output logic                  wr,
  input  logic                  full,
  output logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            gnt,
  output logic                  busy,
  output logic [31:0]           fwd_cnt
);
  localparam int NUM_LANES = 4;
  localparam int MAXC      = (BURST_LEN > STALL_LIMIT) ? BURST_LEN : STALL_LIMIT;
  localparam int CW        = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                                 state, state_n;
  logic [1:0]                             gnt_n, last, last_n, pick, idx;
  logic [CW-1:0]                          beat_cnt, beat_n, stall_cnt, stall_n;
  logic [31:0]                            fwd_n;
  logic                                   found;
  logic [NUM_LANES-1:0]                   vld_v, rd_v;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]   dout_v, dout_m;

  assign vld_v  = {vld3, vld2, vld1, vld0};
  assign dout_v = {dout3, dout2, dout1, dout0};
  assign {rd3, rd2, rd1, rd0} = rd_v;

  assign busy = (state == BURST);
  // rst gate keeps the strobes quiet in the reset cycle even mid-burst
  assign wr   = busy & vld_v[gnt] & ~full & ~rst;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pe_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel    (busy && (gnt == 2'(i))),
      .wr     (wr),
      .dout   (dout_v[i]),
      .rd     (rd_v[i]),
      .dout_m (dout_m[i])
    );
  end

  always_comb begin
    din = '0;
    for (int i = 0; i < NUM_LANES; i++) din = din | dout_m[i];
  end

  // first requester after the previous owner, wrapping mod 4
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = last + 2'(k);
      if (!found && vld_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    beat_n  = beat_cnt;
    stall_n = stall_cnt;
    fwd_n   = fwd_cnt + 32'(wr);
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = pick;
          beat_n  = '0;
          stall_n = '0;
          state_n = BURST;
        end
      end
      BURST: begin
        if (wr) begin
          beat_n  = beat_cnt + 1'b1;
          stall_n = '0;
          if (beat_cnt == CW'(BURST_LEN - 1)) begin
            state_n = IDLE;
            last_n  = gnt;
            beat_n  = '0;
          end
        end else if (!vld_v[gnt]) begin
          if (stall_cnt == CW'(STALL_LIMIT - 1)) begin
            state_n = IDLE;
            last_n  = gnt;
            stall_n = '0;
            beat_n  = '0;
          end else begin
            stall_n = stall_cnt + 1'b1;
          end
        end
        // vld high with full high: backpressure, counters held
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= 2'd3;
      beat_cnt  <= '0;
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      last      <= last_n;
      beat_cnt  <= beat_n;
      stall_cnt <= stall_n;
      fwd_cnt   <= fwd_n;
    end
  end
endmodule

// File: tb/tb_pe_arbiter.sv
// Directed bench for pe_arbiter: reset, single requester, round-robin,
// backpressure, stall release, and mid-burst reset.

module tb_pe_arbiter;
  logic         clk, rst, full, wr, busy;
  logic         rd0, rd1, rd2, rd3;
  logic [3:0]   vld, rd_v, rq;
  logic [127:0] dout [4];
  logic [127:0] din, edin;
  logic [1:0]   gnt, eg;
  logic [31:0]  fwd_cnt;
  logic         eb, ew;
  logic [3:0]   er;
  int           vectors = 0, misses = 0;
  int           nb, n3;

  assign rd_v = {rd3, rd2, rd1, rd0};

  pe_arbiter dut (
    .clk(clk), .rst(rst),
    .rd0(rd0), .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .vld0(vld[0]), .vld1(vld[1]), .vld2(vld[2]), .vld3(vld[3]),
    .dout0(dout[0]), .dout1(dout[1]), .dout2(dout[2]), .dout3(dout[3]),
    .wr(wr), .full(full), .din(din), .gnt(gnt), .busy(busy), .fwd_cnt(fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; vld = 4'h0; full = 1'b0;
    for (int i = 0; i < 4; i++) dout[i] = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({busy, wr, rd_v} !== 6'b0) begin
        misses++; $display("FAIL reset_hold got %b want 000000", {busy, wr, rd_v});
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, wr, rd_v} !== 6'b0) begin
        misses++; $display("FAIL reset_idle c%0d got %b want 000000", c, {busy, wr, rd_v});
      end
      vectors++;
      if (fwd_cnt !== 32'd0) begin
        misses++; $display("FAIL reset_fwd c%0d got %0d want 0", c, fwd_cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    vld = 4'b0100; dout[2] = 128'h10; nb = 0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      eb   = !(c == 0 || c == 5 || c == 10);
      er   = eb ? 4'b0100 : 4'b0000;
      edin = eb ? 128'h10 + 128'(nb) : '0;
      vectors++;
      if ({busy, wr, rd_v} !== {eb, eb, er}) begin
        misses++; $display("FAIL single_ctl c%0d got %b want %b", c, {busy, wr, rd_v}, {eb, eb, er});
      end
      if (eb) begin
        vectors++;
        if (gnt !== 2'd2) begin misses++; $display("FAIL single_gnt c%0d got %0d want 2", c, gnt); end
      end
      vectors++;
      if (din !== edin) begin misses++; $display("FAIL single_din c%0d got %h want %h", c, din, edin); end
      if (c == 10) begin
        vectors++;
        if (fwd_cnt !== 32'd8) begin misses++; $display("FAIL single_fwd got %0d want 8", fwd_cnt); end
      end
      if (eb) nb++;
      rq = rd_v;
      @(posedge clk); #1;
      if (rq[2]) dout[2] = dout[2] + 1;
      if (c == 9) vld = 4'h0;
    end
  endtask

  task automatic test_all_four();
    rst = 1'b1; vld = 4'hF;
    for (int i = 0; i < 4; i++) dout[i] = 128'hA0 + 128'(i);
    @(negedge clk);
    vectors++;
    if ({wr, rd_v} !== 5'b0) begin misses++; $display("FAIL rr_rst got %b want 00000", {wr, rd_v}); end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      eb   = (c % 5) != 0;
      eg   = 2'((c / 5) % 4);
      er   = eb ? (4'b0001 << eg) : 4'b0000;
      edin = eb ? 128'hA0 + 128'(eg) : '0;
      vectors++;
      if ({busy, wr, rd_v} !== {eb, eb, er}) begin
        misses++; $display("FAIL rr_ctl c%0d got %b want %b", c, {busy, wr, rd_v}, {eb, eb, er});
      end
      if (eb) begin
        vectors++;
        if (gnt !== eg) begin misses++; $display("FAIL rr_gnt c%0d got %0d want %0d", c, gnt, eg); end
      end
      vectors++;
      if (din !== edin) begin misses++; $display("FAIL rr_din c%0d got %h want %h", c, din, edin); end
      if (c == 25) begin
        vectors++;
        if (fwd_cnt !== 32'd20) begin misses++; $display("FAIL rr_fwd got %0d want 20", fwd_cnt); end
      end
      @(posedge clk); #1;
      if (c == 24) vld = 4'h0;
    end
  endtask

  task automatic test_backpressure();
    vld = 4'b0010; dout[1] = 128'h100; nb = 0;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      eb   = (c != 0) && (c != 25);
      ew   = eb && !(c >= 3 && c <= 22);
      er   = ew ? 4'b0010 : 4'b0000;
      edin = eb ? 128'h100 + 128'(nb) : '0;
      vectors++;
      if ({busy, wr, rd_v} !== {eb, ew, er}) begin
        misses++; $display("FAIL bp_ctl c%0d got %b want %b", c, {busy, wr, rd_v}, {eb, ew, er});
      end
      if (eb) begin
        vectors++;
        if (gnt !== 2'd1) begin misses++; $display("FAIL bp_gnt c%0d got %0d want 1", c, gnt); end
      end
      vectors++;
      if (din !== edin) begin misses++; $display("FAIL bp_din c%0d got %h want %h", c, din, edin); end
      if (c == 25) begin
        vectors++;
        if (fwd_cnt !== 32'd24) begin misses++; $display("FAIL bp_fwd got %0d want 24", fwd_cnt); end
      end
      if (ew) nb++;
      rq = rd_v;
      @(posedge clk); #1;
      if (rq[1]) dout[1] = dout[1] + 1;
      if (c == 2)  full = 1'b1;
      if (c == 22) full = 1'b0;
      if (c == 24) vld = 4'h0;
    end
  endtask

  task automatic test_stall();
    vld = 4'b1000; dout[3] = 128'h300; dout[0] = 128'h500; n3 = 0;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      eb   = (c != 0) && (c != 10);
      eg   = (c <= 9) ? 2'd3 : 2'd0;
      ew   = (c == 1) || (c == 11);
      er   = ew ? (4'b0001 << eg) : 4'b0000;
      edin = !eb ? '0 : (eg == 2'd3) ? ((c == 1) ? 128'h300 : 128'h301) : 128'h500;
      vectors++;
      if ({busy, wr, rd_v} !== {eb, ew, er}) begin
        misses++; $display("FAIL stall_ctl c%0d got %b want %b", c, {busy, wr, rd_v}, {eb, ew, er});
      end
      if (eb) begin
        vectors++;
        if (gnt !== eg) begin misses++; $display("FAIL stall_gnt c%0d got %0d want %0d", c, gnt, eg); end
      end
      vectors++;
      if (din !== edin) begin misses++; $display("FAIL stall_din c%0d got %h want %h", c, din, edin); end
      if (c == 10) begin
        vectors++;
        if (fwd_cnt !== 32'd25) begin misses++; $display("FAIL stall_fwd got %0d want 25", fwd_cnt); end
      end
      rq = rd_v;
      if (rq[3]) n3++;
      @(posedge clk); #1;
      if (rq[3]) dout[3] = dout[3] + 1;
      if (c == 1) vld = 4'b0001;
    end
    vectors++;
    if (n3 !== 1) begin misses++; $display("FAIL stall_port3_beats got %0d want 1", n3); end
  endtask

  task automatic test_mid_reset();
    // now in beat 2 of the port 0 burst
    rst = 1'b1; vld = 4'hF;
    @(negedge clk);
    vectors++;
    if ({wr, rd_v} !== 5'b0) begin misses++; $display("FAIL mrst_strobe got %b want 00000", {wr, rd_v}); end
    vectors++;
    if (fwd_cnt !== 32'd26) begin misses++; $display("FAIL mrst_fwd_pre got %0d want 26", fwd_cnt); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, fwd_cnt} !== {1'b0, 32'd0}) begin
      misses++; $display("FAIL mrst_after got busy=%b fwd=%0d want busy=0 fwd=0", busy, fwd_cnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({busy, gnt, wr, rd_v} !== {1'b1, 2'd0, 1'b1, 4'b0001}) begin
      misses++; $display("FAIL mrst_first_gnt got %b want 1001 0001", {busy, gnt, wr, rd_v});
    end
    vectors++;
    if (din !== 128'h500) begin misses++; $display("FAIL mrst_din got %h want 500", din); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_stall();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
